// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: one-hot states,
// grant encodings and the byte-strobe width helper.
package mem_arb_pkg;

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_REQ  = 3'b010;
  localparam logic [2:0] S_RESP = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_REQ  = S_REQ,
    ST_RESP = S_RESP
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_I    = 2'd1;
  localparam logic [1:0] GNT_D    = 2'd2;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch (I) and load/store (D) requests.
// Round-robin on last grant when MEM_ARB_RR_EN is defined, else fixed D-over-I.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_valid,
  input  logic       d_valid,
  input  logic       last_grant_d,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    gnt = GNT_NONE;
    if (i_valid && d_valid) begin
      // The requester that did not win last time goes first.
      gnt = last_grant_d ? GNT_I : GNT_D;
    end else if (d_valid) begin
      gnt = GNT_D;
    end else if (i_valid) begin
      gnt = GNT_I;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_d;

  always_comb begin
    gnt = GNT_NONE;
    if (d_valid) begin
      gnt = GNT_D;
    end else if (i_valid) begin
      gnt = GNT_I;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory request/response port between fetch (I) and load/store (D),
// one transaction outstanding. MEM_ARB_RR_EN selects round-robin arbitration.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both high;
// valid never drops before its transfer and the payload is stable while valid.
// The *_Req_Ready outputs are one-cycle grant pulses raised only in IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   I_Req_Addr,
  input  logic                I_Req_Valid,
  output logic                I_Req_Ready,
  output logic [DATA_W-1:0]   I_Resp_Data,
  output logic                I_Resp_Valid,
  input  logic                I_Resp_Ready,
  input  logic [ADDR_W-1:0]   D_Req_Addr,
  input  logic [DATA_W-1:0]   D_Req_Wdata,
  input  logic [DATA_W/8-1:0] D_Req_Wstrb,
  input  logic                D_Req_Write,
  input  logic                D_Req_Valid,
  output logic                D_Req_Ready,
  output logic [DATA_W-1:0]   D_Resp_Data,
  output logic                D_Resp_Valid,
  input  logic                D_Resp_Ready,
  output logic [ADDR_W-1:0]   M_Req_Addr,
  output logic [DATA_W-1:0]   M_Req_Wdata,
  output logic [DATA_W/8-1:0] M_Req_Wstrb,
  output logic                M_Req_Write,
  output logic                M_Req_Valid,
  input  logic                M_Req_Ready,
  input  logic [DATA_W-1:0]   M_Resp_Data,
  input  logic                M_Resp_Valid,
  output logic                M_Resp_Ready,
  output logic [2:0]          dbg_state
);

  localparam int STRB_W = strb_w(DATA_W);

  state_t              state_q, state_d;
  logic [1:0]          gnt_q;
  logic [1:0]          pick_gnt;
  logic                grant_fire;
  logic                last_grant_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                write_q;

  mem_arb_pick u_pick (
    .i_valid      (I_Req_Valid),
    .d_valid      (D_Req_Valid),
    .last_grant_d (last_grant_d),
    .gnt          (pick_gnt)
  );

  // Grant is suppressed while rst is high so no pulse is lost to the reset.
  assign grant_fire = (state_q == ST_IDLE) && !rst && (pick_gnt != GNT_NONE);

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_d <= 1'b0;
    end else if (grant_fire) begin
      last_grant_d <= (pick_gnt == GNT_D);
    end
  end
`else
  assign last_grant_d = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    I_Req_Ready  = 1'b0;
    D_Req_Ready  = 1'b0;
    M_Req_Valid  = 1'b0;
    M_Resp_Ready = 1'b0;
    I_Resp_Valid = 1'b0;
    D_Resp_Valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_fire) begin
          I_Req_Ready = (pick_gnt == GNT_I);
          D_Req_Ready = (pick_gnt == GNT_D);
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        M_Req_Valid = 1'b1;
        if (M_Req_Ready) begin
          state_d = write_q ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (gnt_q == GNT_D) begin
          M_Resp_Ready = D_Resp_Ready;
          D_Resp_Valid = M_Resp_Valid;
        end else begin
          M_Resp_Ready = I_Resp_Ready;
          I_Resp_Valid = M_Resp_Valid;
        end
        if (M_Resp_Valid && M_Resp_Ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_fire) begin
        gnt_q <= pick_gnt;
        if (pick_gnt == GNT_D) begin
          addr_q  <= D_Req_Addr;
          wdata_q <= D_Req_Wdata;
          wstrb_q <= D_Req_Wstrb;
          write_q <= D_Req_Write;
        end else begin
          // Fetches are always reads with no byte lanes enabled.
          addr_q  <= I_Req_Addr;
          wdata_q <= '0;
          wstrb_q <= '0;
          write_q <= 1'b0;
        end
      end else if (state_d == ST_IDLE) begin
        gnt_q <= GNT_NONE;
      end
    end
  end

  assign M_Req_Addr  = addr_q;
  assign M_Req_Wdata = wdata_q;
  assign M_Req_Wstrb = wstrb_q;
  assign M_Req_Write = write_q;
  assign I_Resp_Data = M_Resp_Data;
  assign D_Resp_Data = M_Resp_Data;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk, rst;
  logic [31:0] I_Req_Addr;
  logic        I_Req_Valid, I_Req_Ready;
  logic [31:0] I_Resp_Data;
  logic        I_Resp_Valid, I_Resp_Ready;
  logic [31:0] D_Req_Addr, D_Req_Wdata;
  logic [3:0]  D_Req_Wstrb;
  logic        D_Req_Write, D_Req_Valid, D_Req_Ready;
  logic [31:0] D_Resp_Data;
  logic        D_Resp_Valid, D_Resp_Ready;
  logic [31:0] M_Req_Addr, M_Req_Wdata;
  logic [3:0]  M_Req_Wstrb;
  logic        M_Req_Write, M_Req_Valid, M_Req_Ready;
  logic [31:0] M_Resp_Data;
  logic        M_Resp_Valid, M_Resp_Ready;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  bit m_last_d = 1'b0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .I_Req_Addr(I_Req_Addr), .I_Req_Valid(I_Req_Valid), .I_Req_Ready(I_Req_Ready),
    .I_Resp_Data(I_Resp_Data), .I_Resp_Valid(I_Resp_Valid), .I_Resp_Ready(I_Resp_Ready),
    .D_Req_Addr(D_Req_Addr), .D_Req_Wdata(D_Req_Wdata), .D_Req_Wstrb(D_Req_Wstrb),
    .D_Req_Write(D_Req_Write), .D_Req_Valid(D_Req_Valid), .D_Req_Ready(D_Req_Ready),
    .D_Resp_Data(D_Resp_Data), .D_Resp_Valid(D_Resp_Valid), .D_Resp_Ready(D_Resp_Ready),
    .M_Req_Addr(M_Req_Addr), .M_Req_Wdata(M_Req_Wdata), .M_Req_Wstrb(M_Req_Wstrb),
    .M_Req_Write(M_Req_Write), .M_Req_Valid(M_Req_Valid), .M_Req_Ready(M_Req_Ready),
    .M_Resp_Data(M_Resp_Data), .M_Resp_Valid(M_Resp_Valid), .M_Resp_Ready(M_Resp_Ready),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration rules
  function automatic int model_pick(input bit iv, input bit dv);
    if (!iv && !dv) return GNT_NONE;
    if (iv && !dv) return GNT_I;
    if (dv && !iv) return GNT_D;
`ifdef MEM_ARB_RR_EN
    return m_last_d ? GNT_I : GNT_D;
`else
    return GNT_D;
`endif
  endfunction

  task automatic model_grant(input int win);
    if (win != GNT_NONE) m_last_d = (win == GNT_D);
  endtask

  task automatic idle_inputs();
    I_Req_Valid = 0; D_Req_Valid = 0; D_Req_Write = 0;
    M_Req_Ready = 0; M_Resp_Valid = 0; I_Resp_Ready = 0; D_Resp_Ready = 0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ireqrdy"}, I_Req_Ready, 0);
    chk({tag, "_dreqrdy"}, D_Req_Ready, 0);
    chk({tag, "_mreqvld"}, M_Req_Valid, 0);
    chk({tag, "_mresprdy"}, M_Resp_Ready, 0);
    chk({tag, "_irespvld"}, I_Resp_Valid, 0);
    chk({tag, "_drespvld"}, D_Resp_Valid, 0);
    chk({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  // Driver: one full transaction starting from IDLE
  task automatic do_txn(input bit iv, input bit dv, input bit dw,
                        input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [3:0] ds,
                        input logic [31:0] rd, input int req_wait, input int resp_wait);
    int win;
    logic [31:0] ea, ew;
    logic [3:0] es;
    logic ewr;
    @(negedge clk);
    I_Req_Addr = ia; I_Req_Valid = iv;
    D_Req_Addr = da; D_Req_Wdata = dwd; D_Req_Wstrb = ds; D_Req_Write = dw; D_Req_Valid = dv;
    #1;
    win = model_pick(iv, dv);
    chk("grant_i", I_Req_Ready, win == GNT_I);
    chk("grant_d", D_Req_Ready, win == GNT_D);
    chk("grant_mvld", M_Req_Valid, 0);
    model_grant(win);
    if (win == GNT_NONE) return;
    if (win == GNT_D) begin ea = da; ew = dwd; es = ds; ewr = dw; end
    else begin ea = ia; ew = 0; es = 0; ewr = 0; end

    for (int k = 0; k <= req_wait; k++) begin
      @(negedge clk);
      I_Req_Valid = 0; D_Req_Valid = 0;
      M_Req_Ready = (k == req_wait);
      M_Resp_Valid = 1'($urandom_range(0, 1));
      #1;
      chk("req_valid", M_Req_Valid, 1);
      chk("req_addr", M_Req_Addr, ea);
      chk("req_wdata", M_Req_Wdata, ew);
      chk("req_wstrb", M_Req_Wstrb, es);
      chk("req_write", M_Req_Write, ewr);
      chk("req_irespvld", I_Resp_Valid, 0);
      chk("req_drespvld", D_Resp_Valid, 0);
      chk("req_mresprdy", M_Resp_Ready, 0);
      chk("req_nogrant", I_Req_Ready | D_Req_Ready, 0);
    end

    @(negedge clk);
    M_Req_Ready = 0; M_Resp_Valid = 0;
    if (ewr) begin
      #1;
      check_quiet("wr_done");
      return;
    end

    exp_q.push_back(rd);
    for (int k = 0; k <= resp_wait; k++) begin
      if (k > 0) @(negedge clk);
      M_Resp_Valid = 1; M_Resp_Data = rd;
      I_Resp_Ready = (win == GNT_I) ? (k == resp_wait) : 1'($urandom_range(0, 1));
      D_Resp_Ready = (win == GNT_D) ? (k == resp_wait) : 1'($urandom_range(0, 1));
      #1;
      chk("resp_state", dbg_state, S_RESP);
      chk("resp_win_vld", (win == GNT_D) ? D_Resp_Valid : I_Resp_Valid, 1);
      chk("resp_lose_vld", (win == GNT_D) ? I_Resp_Valid : D_Resp_Valid, 0);
      chk("resp_mrdy", M_Resp_Ready, k == resp_wait);
      chk("resp_mreqvld", M_Req_Valid, 0);
      if (k == resp_wait)
        chk("resp_data", (win == GNT_D) ? D_Resp_Data : I_Resp_Data, exp_q.pop_front());
    end
    @(negedge clk);
    M_Resp_Valid = 0; I_Resp_Ready = 0; D_Resp_Ready = 0;
    #1;
    check_quiet("rd_done");
  endtask

  // Continuous contention between I at 0x100 and a D load at 0x200
  task automatic contention();
    int n_gr, cyc, win, prev, ngoal;
    bit drop_i, drop_d;
`ifdef MEM_ARB_RR_EN
    ngoal = 4;
`else
    ngoal = 2;
`endif
    n_gr = 0; cyc = 0; prev = GNT_NONE; drop_i = 0; drop_d = 0;
    @(negedge clk);
    I_Req_Addr = 32'h100; D_Req_Addr = 32'h200; D_Req_Write = 0;
    I_Req_Valid = 1; D_Req_Valid = 1;
    M_Req_Ready = 1; M_Resp_Valid = 1; M_Resp_Data = $urandom;
    I_Resp_Ready = 1; D_Resp_Ready = 1;
    #1;
    while (n_gr < ngoal && cyc < 60) begin
      if (I_Req_Ready || D_Req_Ready) begin
        win = model_pick(I_Req_Valid, D_Req_Valid);
        chk("cont_i", I_Req_Ready, win == GNT_I);
        chk("cont_d", D_Req_Ready, win == GNT_D);
`ifdef MEM_ARB_RR_EN
        if (prev != GNT_NONE) chk("cont_alternate", win != prev, 1);
`else
        chk("cont_order", win, (n_gr == 0) ? GNT_D : GNT_I);
        drop_i = (win == GNT_I); drop_d = (win == GNT_D);
`endif
        model_grant(win);
        prev = win;
        n_gr++;
      end
      @(negedge clk);
      cyc++;
      if (drop_i) I_Req_Valid = 0;
      if (drop_d) D_Req_Valid = 0;
      drop_i = 0; drop_d = 0;
      #1;
    end
    chk("cont_grants", n_gr, ngoal);
    I_Req_Valid = 0; D_Req_Valid = 0;
    repeat (4) @(negedge clk);
    idle_inputs();
    #1;
    check_quiet("cont_end");
  endtask

  initial begin
    rst = 1;
    I_Req_Addr = 0; D_Req_Addr = 0; D_Req_Wdata = 0; D_Req_Wstrb = 0; M_Resp_Data = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    chk("reset_addr", M_Req_Addr, 0);
    chk("reset_wdata", M_Req_Wdata, 0);
    chk("reset_wstrb", M_Req_Wstrb, 0);
    chk("reset_write", M_Req_Write, 0);
    rst = 0;
    m_last_d = 0;

    // I-only read, zero wait
    do_txn(1, 0, 0, 32'h0000_1000, 32'h0, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0);
    // D store with three wait cycles on the request
    do_txn(0, 1, 1, 32'h0, 32'h2004, 32'h1234_5678, 4'b0011, 32'h0, 3, 0);
    // D load with response backpressure
    do_txn(0, 1, 0, 32'h0, 32'h3008, 32'h0, 4'hF, 32'hCAFE_F00D, 0, 2);
    // Simultaneous requests, with the loser dropping after losing
    do_txn(1, 1, 0, 32'h100, 32'h200, 32'h0, 4'h0, 32'h0BAD_0001, 0, 0);
    contention();

    for (int t = 0; t < 30; t++) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while in RESP
    @(negedge clk);
    D_Req_Addr = 32'h4000; D_Req_Write = 0; D_Req_Valid = 1;
    @(negedge clk);
    D_Req_Valid = 0; M_Req_Ready = 1;
    @(negedge clk);
    M_Req_Ready = 0;
    #1;
    chk("mid_resp_state", dbg_state, S_RESP);
    rst = 1;
    @(negedge clk);
    #1;
    check_quiet("rst_resp");
    chk("rst_resp_addr", M_Req_Addr, 0);
    rst = 0;
    m_last_d = 0;
    do_txn(1, 0, 0, 32'h0000_5000, 32'h0, 32'h0, 4'h0, 32'h5555_AAAA, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares a single memory request/response port between the instruction-fetch requester (I) and the load/store requester (D) of the multicycle RISC-V core. One transaction is outstanding at a time. Request fields are latched at grant and held stable downstream. Read data is routed back to the granting requester; writes complete on the downstream request handshake.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
clk  in  1  clock
rst  in  1  reset
I_Req_Addr  in  ADDR_W  fetch address
I_Req_Valid  in  1  fetch request valid
I_Req_Ready  out  1  fetch request accepted (grant pulse)
I_Resp_Data  out  DATA_W  fetch data
I_Resp_Valid  out  1  fetch data valid
I_Resp_Ready  in  1  fetch side ready for data
D_Req_Addr  in  ADDR_W  load/store address
D_Req_Wdata  in  DATA_W  store data
D_Req_Wstrb  in  DATA_W/8  byte strobes
D_Req_Write  in  1  1=store, 0=load
D_Req_Valid  in  1  data request valid
D_Req_Ready  out  1  data request accepted (grant pulse)
D_Resp_Data  out  DATA_W  load data
D_Resp_Valid  out  1  load data valid
D_Resp_Ready  in  1  load side ready
M_Req_Addr  out  ADDR_W  latched address
M_Req_Wdata  out  DATA_W  latched store data
M_Req_Wstrb  out  DATA_W/8  latched strobes (0 for fetch)
M_Req_Write  out  1  latched write flag (0 for fetch)
M_Req_Valid  out  1  downstream request valid
M_Req_Ready  in  1  downstream accepts request
M_Resp_Data  in  DATA_W  downstream read data
M_Resp_Valid  in  1  downstream read data valid
M_Resp_Ready  out  1  arbiter ready for read data

Behaviour:
- Reset is synchronous and active-high on rst, single clock clk. On reset: state IDLE, grant=none, all Valid/Ready outputs 0, latched M_Req_* fields 0.
- FSM is one-hot: IDLE, REQ, RESP.
- IDLE:
  - If D_Req_Valid or I_Req_Valid, pick a winner. Fixed priority is D over I.
  - Assert the winner's *_Req_Ready combinationally in the same cycle (exactly one cycle).
  - Latch addr/wdata/wstrb/write and the grant. I grants force write=0 and wstrb=0.
  - Go to REQ. With no request, stay in IDLE.
- REQ:
  - M_Req_Valid=1, fields held stable.
  - On M_Req_Ready: a write goes to IDLE; a read goes to RESP.
  - Otherwise stay in REQ. Valid is never dropped before the handshake.
- RESP:
  - M_Resp_Ready = granted requester's *_Resp_Ready.
  - Granted *_Resp_Valid = M_Resp_Valid, and *_Resp_Data = M_Resp_Data.
  - The non-granted *_Resp_Valid is 0.
  - On the M_Resp_Valid && M_Resp_Ready handshake, go to IDLE.
- Outside RESP: M_Resp_Ready=0 and both *_Resp_Valid=0. *_Resp_Data may carry M_Resp_Data unconditionally.
- Latency: grant cycle, then the earliest downstream handshake one cycle later. A zero-wait read returns to IDLE 3 cycles after the grant cycle. Back-to-back transactions have one idle-state cycle between them.
- Simultaneous I and D valid in IDLE: D wins and I stays pending. The I requester must hold I_Req_Valid; the arbiter keeps no request queue.
- A requester dropping Valid while not granted is permitted and has no effect.
- M_Resp_Valid in IDLE or REQ is ignored (protocol error; not absorbed).
- rst in any state aborts immediately to IDLE with outputs as at reset. The downstream memory shares rst.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A one-bit last-grant register (reset = I granted last) gives priority to the requester not granted last. It updates on each grant.
- Undefined: fixed D-over-I priority and no last-grant register.

Decomposition:
- Package mem_arb_pkg holds:
  - state one-hot localparams S_IDLE=3'b001, S_REQ=3'b010, S_RESP=3'b100;
  - grant encodings GNT_NONE, GNT_I, GNT_D (2-bit);
  - strobe width function DATA_W/8.
- One sub-module mem_arb_pick: combinational winner select from (i_valid, d_valid, last_grant). It contains the RR/fixed logic under MEM_ARB_RR_EN.

Test Plan:
- I-only read:
  - Stimulus: I_Req_Addr=0x0000_1000 valid, M_Req_Ready immediate, M_Resp_Data=0xDEADBEEF one cycle later.
  - Expect: I_Req_Ready pulse; M_Req_Addr=0x1000 with write=0 and wstrb=0; I_Resp_Valid with 0xDEADBEEF; D_Resp_Valid stays 0.
- D store:
  - Stimulus: addr 0x2004, wdata 0x12345678, wstrb 4'b0011, write=1; M_Req_Ready held low 3 cycles.
  - Expect: M_Req_Valid held 4 cycles with stable fields; return to IDLE after the handshake; no RESP state.
- Simultaneous I (0x100) and D load (0x200) valid:
  - Fixed build: D granted first, I granted at the next IDLE.
  - With MEM_ARB_RR_EN: first grant follows the last-grant state; continuous contention alternates D, I, D, I.
- Response backpressure:
  - Stimulus: D load, D_Resp_Ready low 2 cycles while M_Resp_Valid=1.
  - Expect: M_Resp_Ready low for those 2 cycles; D_Resp_Valid high throughout; completion on the cycle D_Resp_Ready rises.
- Reset mid-RESP:
  - Stimulus: assert rst while in RESP.
  - Expect: next cycle all Valid/Ready outputs 0 and FSM in IDLE; a new I request afterwards is granted normally.
